lane_mem_arb: RTL

LANE_MEM_ARB -- requirements
Module: lane_mem_arb

---
 rtl/lane_mem_arb_pkg.sv | 11 +
 rtl/lane_mem_arb_tag_fifo.sv | 67 ++++++
 rtl/lane_mem_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lane_mem_arb_pkg.sv
// Shared defaults and the requester id type for the lane DMA memory arbiter.
package lane_mem_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_W    = 24;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_TAG_DEPTH = 8;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/lane_mem_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads that are outstanding at the memory controller.
module lane_mem_arb_tag_fifo
    import lane_mem_arb_pkg::*;
#(
    parameter int ID_W  = $bits(req_id_t),
    parameter int DEPTH = DEF_TAG_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     push_i,
    input  logic [ID_W-1:0]          push_id_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [ID_W-1:0]          head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is not reset; entries are only read once count marks them valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lane_mem_arb.sv
// Round-robin arbiter sharing one memory controller port among lane DMA requesters,
// with zero-latency forwarding and in-order read response routing via an id FIFO.
module lane_mem_arb
    import lane_mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_poweron,
    input  logic [NUM_REQ-1:0]          dma__arb__write_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   dma__arb__write_address,
    input  logic [NUM_REQ*DATA_W-1:0]   dma__arb__write_data,
    output logic [NUM_REQ-1:0]          arb__dma__write_ready,
    input  logic [NUM_REQ-1:0]          dma__arb__read_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   dma__arb__read_address,
    output logic [NUM_REQ-1:0]          arb__dma__read_ready,
    output logic [NUM_REQ-1:0]          arb__dma__read_data_valid,
    output logic [DATA_W-1:0]           arb__dma__read_data,
    output logic                        arb__memc__write_valid,
    output logic [ADDR_W-1:0]           arb__memc__write_address,
    output logic [DATA_W-1:0]           arb__memc__write_data,
    input  logic                        memc__arb__write_ready,
    output logic                        arb__memc__read_valid,
    output logic [ADDR_W-1:0]           arb__memc__read_address,
    input  logic                        memc__arb__read_ready,
    input  logic                        memc__arb__read_data_valid,
    input  logic [DATA_W-1:0]           memc__arb__read_data,
    output logic                        arb__err_unexpected_rsp
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]            rrp_q, rrp_d;
    logic                       err_q, err_d;
    logic [NUM_REQ-1:0]         eligible;
    logic [ID_W-1:0]            winner, cand;
    logic                       found, sel_write, sel_read, accept, push, pop;
    logic                       tag_full, tag_empty;
    logic [ID_W-1:0]            tag_head;
    logic [$clog2(TAG_DEPTH):0] unused_tag_count;
    int                         idx;

    // A full tag FIFO blocks reads outright, even when a response frees a slot this cycle.
    assign eligible = dma__arb__write_valid | (dma__arb__read_valid & {NUM_REQ{~tag_full}});

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rrp_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel_write = found & dma__arb__write_valid[winner];
    assign sel_read  = found & ~dma__arb__write_valid[winner] & dma__arb__read_valid[winner] & ~tag_full;

    always_comb begin
        arb__memc__write_valid   = sel_write;
        arb__memc__write_address = '0;
        arb__memc__write_data    = '0;
        arb__memc__read_valid    = sel_read;
        arb__memc__read_address  = '0;
        arb__dma__write_ready    = '0;
        arb__dma__read_ready     = '0;
        if (sel_write) begin
            arb__memc__write_address      = dma__arb__write_address[winner*ADDR_W +: ADDR_W];
            arb__memc__write_data         = dma__arb__write_data[winner*DATA_W +: DATA_W];
            arb__dma__write_ready[winner] = memc__arb__write_ready;
        end
        if (sel_read) begin
            arb__memc__read_address      = dma__arb__read_address[winner*ADDR_W +: ADDR_W];
            arb__dma__read_ready[winner] = memc__arb__read_ready;
        end
    end

    assign push   = sel_read & memc__arb__read_ready;
    assign accept = (sel_write & memc__arb__write_ready) | push;
    assign pop    = memc__arb__read_data_valid & ~tag_empty;

    always_comb begin
        rrp_d = rrp_q;
        if (accept) rrp_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
    end

    always_comb begin
        arb__dma__read_data_valid = '0;
        if (pop) arb__dma__read_data_valid[tag_head] = 1'b1;
    end

    assign arb__dma__read_data     = memc__arb__read_data;
    assign err_d                   = err_q | (memc__arb__read_data_valid & tag_empty);
    assign arb__err_unexpected_rsp = err_q;

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            rrp_q <= '0;
            err_q <= 1'b0;
        end else begin
            rrp_q <= rrp_d;
            err_q <= err_d;
        end
    end

    lane_mem_arb_tag_fifo #(
        .ID_W  (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push_i        (push),
        .push_id_i     (winner),
        .pop_i         (pop),
        .full_o        (tag_full),
        .empty_o       (tag_empty),
        .head_o        (tag_head),
        .count_o       (unused_tag_count)
    );

endmodule
